rr_grant_gen: RTL
=================

// Module: rr_grant_gen
// PURPOSE
//  Round-robin arbiter that generates the registered one-hot select consumed by one_hot_mux (sel input).
//  Holds a grant for a whole multi-beat transfer and releases it on end-of-packet acknowledge or requester abort.
//  Sits directly upstream of the data mux in the xregs read/write return path.
// PARAMETERS
//  CNT         5    number of requesters; width of req/gnt
//  TIMEOUT_CYC 255  grant watchdog limit in cycles; used only with ARB_TIMEOUT_EN; must be >=1
// PORTS
//  clk       in   1    clock; all state updates on rising edge
//  rst_n     in   1    asynchronous, active-low reset
//  req       in   CNT  per-requester request level; held high until granted transfer ends
//  ack       in   1    downstream accepted one beat from the granted source
//  eop       in   1    qualifies ack: accepted beat is the last beat of the transfer
//  gnt       out  CNT  registered one-hot grant; drives one_hot_mux sel; all-zero when idle
//  gnt_vld   out  1    |gnt, registered
//  gnt_id    out  $clog2(CNT)  binary index of granted requester; 0 when idle
//  timeout   out  1    one-cycle pulse: grant forcibly released by watchdog
// BEHAVIOUR
//  - Reset (async assert, sync release): gnt=0, gnt_vld=0, gnt_id=0, timeout=0, state=IDLE, ptr=CNT-1.
//  - FSM: IDLE, GRANT. ptr = index of most recently granted requester.
//  - IDLE: if |req, pick first set bit scanning ptr+1, ptr+2, ... wrapping modulo CNT; next edge: gnt=onehot(pick),
//    gnt_id=pick, ptr=pick, state=GRANT. Latency req->gnt = 1 cycle. If req==0 stay IDLE.
//  - GRANT: gnt constant while req[gnt_id]=1 and no release event.
//  - Release event (cycle-evaluated): (ack & eop) | ~req[gnt_id] | watchdog expiry.
//  - On release: if any req bit set other than the released one, or the released one still set, arbitration
//    runs in the same cycle from ptr (released index has lowest priority) and new gnt loads at next edge:
//    zero bubble, back-to-back grants allowed. Else gnt=0, state=IDLE at next edge.
//  - Single requester re-requesting continuously: re-granted back-to-back (it is the only candidate).
//  - ack without eop: no state change. ack while gnt_vld=0: ignored. eop without ack: ignored.
//  - ack&eop in same cycle as req[gnt_id] drop: single release, no double counting.
//  - req bits for non-granted sources may change freely; they never affect gnt during GRANT.
//  - gnt is always one-hot or zero; gnt_id consistent with gnt every cycle.
//  - Reset asserted mid-transfer: all outputs return to reset values immediately (async); no partial state kept.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYC+1)) clears on every grant load and on every ack;
//    increments each GRANT cycle without ack; reaching TIMEOUT_CYC is a release event and pulses timeout=1
//    for the same edge at which gnt changes. Counter resets to 0.
//  - ARB_TIMEOUT_EN undefined: no counter logic; timeout tied 1'b0; TIMEOUT_CYC unused.
// STRUCTURE
//  - Shared include xregs_arb_defs.vh: state encodings ARB_IDLE=1'b0, ARB_GRANT=1'b1; clog2 function macro.
//  - One sub-module: rr_pick (combinational): inputs req, ptr; outputs pick_vld, pick_idx, pick_onehot.
//    Implementation: double-width req rotate/mask priority scan; parameterised on CNT.
//  - Top holds FSM, gnt/gnt_id/ptr registers, optional watchdog counter.
//  - Simulation-only assertion: gnt one-hot-or-zero every cycle (matches one_hot_mux err expectation of 0).
// TESTING  (CNT=5, TIMEOUT_CYC=8 unless stated)
//  1. Reset with req=5'b10101 held -> after rst_n rises, next edge gnt=5'b00001, gnt_id=0; then
//     ack&eop each grant -> gnt sequence 00100, 10000, 00001 (wrap), no idle cycle between.
//  2. req=5'b00010 only, 3 beats ack, eop on 3rd -> gnt=00010 held 3 cycles, re-granted next cycle since req still high.
//  3. Granted id 2, drop req[2] mid-transfer with req=5'b01001 -> next gnt=01000 (id 3), not id 0.
//  4. ack&eop and req drop same cycle, req otherwise 0 -> single release, gnt=0, gnt_vld=0, state IDLE.
//  5. ARB_TIMEOUT_EN, granted id 1, no ack for 8 cycles -> timeout=1 for one cycle, gnt moves to next requester
//     or 0; with 7 idle cycles then ack -> no timeout, counter restarts.
//  6. Assert rst_n=0 asynchronously mid-GRANT -> gnt=0, gnt_vld=0, timeout=0 without waiting for clk edge.

Source files
------------

// File: rtl/rr_grant_gen_pkg.sv
// Shared definitions for the rr_grant_gen round-robin arbiter: FSM state encodings.
package rr_grant_gen_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo CNT.
module rr_pick #(
    parameter int CNT = 5
) (
    input  logic [CNT-1:0]         req,
    input  logic [$clog2(CNT)-1:0] ptr,
    output logic                   pick_vld,
    output logic [$clog2(CNT)-1:0] pick_idx,
    output logic [CNT-1:0]         pick_onehot
);

    localparam int IDW = $clog2(CNT);

    logic [2*CNT-1:0] dbl;
    logic [CNT-1:0]   rot;
    logic             found;
    int               off;
    int               sum;

    always_comb begin
        dbl   = {req, req};
        // Bit k of rot corresponds to requester (ptr + 1 + k) mod CNT.
        rot   = CNT'(dbl >> (int'(ptr) + 1));
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < CNT; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr) + 1 + off;
        if (sum >= CNT) begin
            sum = sum - CNT;
        end
        pick_vld = found;
        pick_idx = IDW'(sum);
        for (int i = 0; i < CNT; i++) begin
            pick_onehot[i] = found && (sum == i);
        end
    end

endmodule

// File: rtl/rr_grant_gen.sv
// Round-robin grant generator holding a registered one-hot select for whole transfers.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_grant_gen
    import rr_grant_gen_pkg::*;
#(
    parameter int CNT         = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT-1:0]         req,
    input  logic                   ack,
    input  logic                   eop,
    output logic [CNT-1:0]         gnt,
    output logic                   gnt_vld,
    output logic [$clog2(CNT)-1:0] gnt_id,
    output logic                   timeout,
    output logic                   state_dbg
);

    localparam int IDW = $clog2(CNT);

    arb_state_e       state_q, state_d;
    logic [CNT-1:0]   gnt_q, gnt_d;
    logic             gnt_vld_q;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic [CNT-1:0]   pick_onehot;
    logic             wd_exp;
    logic             release_ev;
    logic             load_grant;

    rr_pick #(.CNT(CNT)) u_pick (
        .req         (req),
        .ptr         (ptr_q),
        .pick_vld    (pick_vld),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

    // One release per cycle no matter how many causes coincide.
    assign release_ev = (state_q == ARB_GRANT) &&
                        ((ack && eop) || !req[gnt_id_q] || wd_exp);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        load_grant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    load_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (release_ev) begin
                    if (pick_vld) begin
                        load_grant = 1'b1;
                    end else begin
                        state_d  = ARB_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (load_grant) begin
            state_d  = ARB_GRANT;
            gnt_d    = pick_onehot;
            gnt_id_d = pick_idx;
            ptr_d    = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            ptr_q     <= IDW'(CNT - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= |gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int             WDW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q;

    // Expiry is judged on the cycle that would bring the count to TIMEOUT_CYC.
    assign wd_exp = (state_q == ARB_GRANT) && !ack && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (load_grant || ack || (state_d == ARB_IDLE)) begin
            wd_cnt_d = '0;
        end else if (state_q == ARB_GRANT) begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= wd_exp;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_exp  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_vld   = gnt_vld_q;
    assign gnt_id    = gnt_id_q;
    assign state_dbg = logic'(state_q);

`ifndef SYNTHESIS
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    gnt_id_a: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_vld_q ? gnt_q[gnt_id_q] : (gnt_id_q == '0)));
`endif

endmodule
